// File: rtl/vga_sync.sv
// vga_sync: free-running VGA raster timing generator (pixel/line counters plus sync,
// blanking and tick flags).
// Latency: every output is a flop; flags are computed from the next counter values so
// that all outputs describe the same pixel in the same cycle.
// Backpressure: none; the raster advances on every clk_25 edge while rst_n is high.
// Ports:
//   clk_25     in   pixel clock, all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   h_count    out  10-bit current pixel column, 0..H_TOTAL-1
//   v_count    out  10-bit current line, 0..V_TOTAL-1
//   hsync      out  horizontal sync, active low for columns 0..H_PULSE-1
//   vsync      out  vertical sync, active low for lines 0..V_PULSE-1
//   video_on   out  high inside the visible window
//   line_tick  out  high on the last pixel of every line
//   frame_tick out  high on the last pixel of every frame
module vga_sync #(
   parameter int H_TOTAL    = 800,
   parameter int H_PULSE    = 96,
   parameter int H_BP_END   = 144,
   parameter int H_FP_START = 784,
   parameter int V_TOTAL    = 521,
   parameter int V_PULSE    = 2,
   parameter int V_BP_END   = 31,
   parameter int V_FP_START = 511
) (
   input  logic       clk_25,
   input  logic       rst_n,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_tick,
   output logic       frame_tick
);

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_PW    = 10'(H_PULSE);
   localparam logic [9:0] V_PW    = 10'(V_PULSE);
   localparam logic [9:0] H_VIS0  = 10'(H_BP_END);
   localparam logic [9:0] V_VIS0  = 10'(V_BP_END);
   // Front-porch starts may legally equal 1024 (a total of 1024 with no front porch),
   // which does not fit in 10 bits, so the upper window bound is compared in 11 bits.
   localparam logic [10:0] H_VIS1 = 11'(H_FP_START);
   localparam logic [10:0] V_VIS1 = 11'(V_FP_START);

   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       h_wrap;
   logic       v_wrap;
   logic       h_vis_next;
   logic       v_vis_next;

   always_comb begin
      h_wrap = (h_count == H_LAST);
      v_wrap = (v_count == V_LAST);
      h_next = h_wrap ? 10'd0 : h_count + 10'd1;
      v_next = v_count;
      if (h_wrap) begin
         v_next = v_wrap ? 10'd0 : v_count + 10'd1;
      end
      h_vis_next = (h_next >= H_VIS0) && ({1'b0, h_next} < H_VIS1);
      v_vis_next = (v_next >= V_VIS0) && ({1'b0, v_next} < V_VIS1);
   end

   // Flags are registered from the next-state counters so they line up with the
   // counter values that appear on the ports in the same cycle.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         h_count    <= 10'd0;
         v_count    <= 10'd0;
         hsync      <= 1'b0;
         vsync      <= 1'b0;
         video_on   <= 1'b0;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         h_count    <= h_next;
         v_count    <= v_next;
         hsync      <= (h_next >= H_PW);
         vsync      <= (v_next >= V_PW);
         video_on   <= h_vis_next && v_vis_next;
         line_tick  <= (h_next == H_LAST);
         frame_tick <= (h_next == H_LAST) && (v_next == V_LAST);
      end
   end

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: randomized run/reset stimulus against a pixel-index reference model,
// with a negedge monitor popping expected outputs from a scoreboard queue.
// Also checks per-line hsync width, per-frame vsync width, video_on count and frame
// period, plus frame period and video count of a second, tiny-raster instance.
`timescale 1ns/1ps
module tb_vga_sync;

   // Reduced raster keeps runtime small while keeping every region non-trivial.
   localparam int HT = 50, HP = 6, HB = 9, HF = 47;
   localparam int VT = 13, VP = 2, VB = 3, VF = 11;
   localparam int FRAME = HT * VT;

   logic       clk_25 = 1'b0;
   logic       rst_n  = 1'b1;
   logic [9:0] h_count, v_count;
   logic       hsync, vsync, video_on, line_tick, frame_tick;
   logic [9:0] s_h, s_v;
   logic       s_hs, s_vs, s_vid, s_lt, s_ft;

   always #20 clk_25 = ~clk_25;

   vga_sync #(
      .H_TOTAL(HT), .H_PULSE(HP), .H_BP_END(HB), .H_FP_START(HF),
      .V_TOTAL(VT), .V_PULSE(VP), .V_BP_END(VB), .V_FP_START(VF)
   ) dut (
      .clk_25(clk_25), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
      .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .line_tick(line_tick), .frame_tick(frame_tick)
   );

   vga_sync #(
      .H_TOTAL(10), .H_PULSE(2), .H_BP_END(3), .H_FP_START(9),
      .V_TOTAL(4), .V_PULSE(1), .V_BP_END(1), .V_FP_START(3)
   ) dut_s (
      .clk_25(clk_25), .rst_n(rst_n), .h_count(s_h), .v_count(s_v),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
      .line_tick(s_lt), .frame_tick(s_ft)
   );

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       vid;
      logic       lt;
      logic       ft;
   } obs_t;

   obs_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   p     = 0;   // linear pixel index within the frame

   function automatic obs_t model(int idx, bit in_rst);
      obs_t o;
      int   h, v;
      o = '0;
      if (!in_rst) begin
         h     = idx % HT;
         v     = idx / HT;
         o.h   = 10'(h);
         o.v   = 10'(v);
         o.hs  = (h >= HP);
         o.vs  = (v >= VP);
         o.vid = (h >= HB) && (h < HF) && (v >= VB) && (v < VF);
         o.lt  = (h == HT - 1);
         o.ft  = (idx == FRAME - 1);
      end
      return o;
   endfunction

   // One clock: advance the model if the DUT saw rst_n high at the edge, then drive
   // the new reset level between edges and queue the expectation for this cycle.
   task automatic cycle(input bit run);
      @(posedge clk_25);
      if (rst_n) p = (p + 1) % FRAME;
      #2;
      rst_n = run;
      if (!run) p = 0;
      exp_q.push_back(model(p, !run));
   endtask

   initial begin
      int n;
      #1 rst_n = 1'b0;
      repeat (3) cycle(1'b0);
      repeat (4 * FRAME) cycle(1'b1);
      // Reset dropped mid-frame at a fixed interior point.
      while (p != 5 * HT + 20) cycle(1'b1);
      cycle(1'b0);
      for (int s = 0; s < 12; s++) begin
         n = $urandom_range(50, 1500);
         repeat (n) cycle(1'b1);
         n = $urandom_range(1, 3);
         repeat (n) cycle(1'b0);
      end
      repeat (2 * FRAME + 7) cycle(1'b1);
      @(negedge clk_25);
      @(negedge clk_25);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Monitor: pops one expectation per cycle and keeps running aggregates.
   int hs_low = 0, vs_low = 0, vid_cnt = 0, cyc = 0;
   int s_cyc = 0, s_vid_cnt = 0;

   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk_25);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {h_count, v_count, hsync, vsync, video_on, line_tick, frame_tick};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL cycle t=%0t got h=%0d v=%0d hs=%b vs=%b vid=%b lt=%b ft=%b, required h=%0d v=%0d hs=%b vs=%b vid=%b lt=%b ft=%b",
                        $time, a.h, a.v, a.hs, a.vs, a.vid, a.lt, a.ft,
                        e.h, e.v, e.hs, e.vs, e.vid, e.lt, e.ft);
            end
         end
         if (!rst_n) begin
            hs_low = 0; vs_low = 0; vid_cnt = 0; cyc = 0;
            s_cyc = 0; s_vid_cnt = 0;
         end else begin
            cyc++;
            hs_low  += (hsync === 1'b0) ? 1 : 0;
            vs_low  += (vsync === 1'b0) ? 1 : 0;
            vid_cnt += (video_on === 1'b1) ? 1 : 0;
            if (line_tick === 1'b1) begin
               total++;
               if (hs_low != HP) begin
                  bad++;
                  $display("FAIL hsync_width got %0d, required %0d", hs_low, HP);
               end
               hs_low = 0;
            end
            if (frame_tick === 1'b1) begin
               total++;
               if (cyc != FRAME || vs_low != VP * HT || vid_cnt != (HF - HB) * (VF - VB)) begin
                  bad++;
                  $display("FAIL frame_stats got period=%0d vs_low=%0d vid=%0d, required %0d %0d %0d",
                           cyc, vs_low, vid_cnt, FRAME, VP * HT, (HF - HB) * (VF - VB));
               end
               cyc = 0; vs_low = 0; vid_cnt = 0;
            end
            s_cyc++;
            s_vid_cnt += (s_vid === 1'b1) ? 1 : 0;
            if (s_ft === 1'b1) begin
               total++;
               if (s_cyc != 40 || s_vid_cnt != 12 || s_lt !== 1'b1 || s_h != 10'd9 || s_v != 10'd3) begin
                  bad++;
                  $display("FAIL small_frame got period=%0d vid=%0d lt=%b h=%0d v=%0d, required 40 12 1 9 3",
                           s_cyc, s_vid_cnt, s_lt, s_h, s_v);
               end
               s_cyc = 0; s_vid_cnt = 0;
            end
         end
      end
   end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_TOTAL, default 800, pixels per line including blanking.
REQ-002 Parameter H_PULSE, default 96, hsync pulse width in pixels.
REQ-003 Parameter H_BP_END, default 144, first visible pixel column.
REQ-004 Parameter H_FP_START, default 784, first column after the visible region.
REQ-005 Parameter V_TOTAL, default 521, lines per frame including blanking.
REQ-006 Parameter V_PULSE, default 2, vsync pulse width in lines.
REQ-007 Parameter V_BP_END, default 31, first visible line.
REQ-008 Parameter V_FP_START, default 511, first line after the visible region.
REQ-009 clk_25  input  1  pixel clock, 25 MHz; all logic on its rising edge.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 h_count  output  10  current pixel column, 0..H_TOTAL-1.
REQ-012 v_count  output  10  current line, 0..V_TOTAL-1.
REQ-013 hsync  output  1  horizontal sync, active low.
REQ-014 vsync  output  1  vertical sync, active low.
REQ-015 video_on  output  1  high while (h_count, v_count) is inside the visible window.
REQ-016 line_tick  output  1  single-cycle pulse on the last pixel of each line.
REQ-017 frame_tick  output  1  single-cycle pulse on the last pixel of each frame.

Function
REQ-018 All outputs SHALL be driven directly from flip-flops; no combinational path from counters to ports.
REQ-019 All outputs SHALL be mutually aligned: each flag describes the h_count/v_count value presented in the same cycle (the flags are computed from next-state counter values).
REQ-020 h_count SHALL increment by 1 every clk_25 cycle and wrap from H_TOTAL-1 to 0.
REQ-021 v_count SHALL increment by 1 only in the cycle h_count wraps, and wrap from V_TOTAL-1 to 0 when both counters wrap together.
REQ-022 hsync SHALL be 0 for h_count in [0, H_PULSE-1] and 1 otherwise.
REQ-023 vsync SHALL be 0 for v_count in [0, V_PULSE-1] and 1 otherwise.
REQ-024 video_on SHALL be 1 iff H_BP_END <= h_count < H_FP_START and V_BP_END <= v_count < V_FP_START.
REQ-025 line_tick SHALL be 1 iff h_count == H_TOTAL-1.
REQ-026 frame_tick SHALL be 1 iff h_count == H_TOTAL-1 and v_count == V_TOTAL-1; it coincides with a line_tick.
REQ-027 Counter compares SHALL use 10-bit unsigned arithmetic; the parameters SHALL satisfy H_PULSE < H_BP_END < H_FP_START <= H_TOTAL <= 1024, with the equivalent ordering for V.
REQ-028 Defaults SHALL give 640x480 visible pixels at 800x521 total, about 60 Hz frame rate.

Reset
REQ-029 While rst_n == 0: h_count = 0, v_count = 0, hsync = 0, vsync = 0, video_on = 0, line_tick = 0, frame_tick = 0.
REQ-030 Outputs SHALL take their reset values asynchronously on the falling edge of rst_n, independent of clk_25.
REQ-031 On the first rising clk_25 edge after rst_n rises, h_count SHALL become 1 and v_count SHALL remain 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; no tick SHALL be emitted for the partial frame.

Verification
REQ-033 Scenario: release reset, run 2 lines -> h_count 0..799 twice; hsync low exactly 96 cycles per line; line_tick high at h=799 only; v_count goes 0 -> 1 at the wrap.
REQ-034 Scenario: run 2 full frames -> consecutive frame_tick rising edges 416800 cycles apart; vsync low exactly 1600 cycles per frame; v_count wraps 520 -> 0 together with h 799 -> 0.
REQ-035 Scenario: count video_on over 1 frame -> 307200 cycles high, 640 per visible line; first high at (144, 31), last high at (783, 510).
REQ-036 Scenario: boundaries -> video_on = 0 at h=143 and h=784 on line 31; video_on = 0 on lines 30 and 511 at h=144.
REQ-037 Scenario: assert rst_n low between clock edges at (h=400, v=200) -> all outputs reset immediately without a clock edge; after release, h_count = 1 and v_count = 0 on the first edge; no frame_tick until 416800 cycles later.
REQ-038 Scenario: overrides H_TOTAL=10, H_PULSE=2, H_BP_END=3, H_FP_START=9, V_TOTAL=4, V_PULSE=1, V_BP_END=1, V_FP_START=3 -> frame period 40 cycles, video_on high 12 cycles per frame.
